// File: rtl/ball_motion_if.sv
// Frame-rate game-logic bus between the paddle/frame side and the ball motion stage.
// The master drives frame ticks, serve and paddle rows; the slave returns the ball state.
interface ball_motion_if;
   logic        frame_tick;
   logic        serve;
   logic [11:0] l_paddle_center_row;
   logic [11:0] r_paddle_center_row;
   logic [11:0] ball_center_col;
   logic [11:0] ball_center_row;
   logic [3:0]  score_p0;
   logic [3:0]  score_p1;
   logic        point_scored;
   logic        game_over;

   modport master (
      output frame_tick, serve, l_paddle_center_row, r_paddle_center_row,
      input  ball_center_col, ball_center_row, score_p0, score_p1, point_scored, game_over
   );

   modport slave (
      input  frame_tick, serve, l_paddle_center_row, r_paddle_center_row,
      output ball_center_col, ball_center_row, score_p0, score_p1, point_scored, game_over
   );
endinterface

// File: rtl/ball_motion.sv
// Ball position, wall/paddle bounces, scoring and serve sequencing, advanced once per frame.
// Optional macro BALL_SPEEDUP_EN: horizontal speed rises by one every fourth paddle hit.
module ball_motion #(
   parameter int DISP_COLS           = 800,
   parameter int DISP_ROWS           = 600,
   parameter int PADDLE_HEIGHT       = 44,
   parameter int PADDLE_WIDTH        = 12,
   parameter int L_PADDLE_CENTER_COL = 15,
   parameter int R_PADDLE_CENTER_COL = DISP_COLS - 15,
   parameter int BALL_HEIGHT         = 8,
   parameter int BALL_WIDTH          = 6,
   parameter int BALL_SPEED_X        = 4,
   parameter int BALL_SPEED_Y        = 2,
   parameter int SCORE_MAX           = 7,
   parameter int SCORE_HOLD_FRAMES   = 60
) (
   input logic          clk,
   input logic          rst_n,
   ball_motion_if.slave bus
);
   typedef enum logic [1:0] {SERVE_WAIT, PLAY, SCORED, GAME_OVER} state_t;

   localparam logic [11:0]        CENTER_COL = 12'(DISP_COLS / 2);
   localparam logic [11:0]        CENTER_ROW = 12'(DISP_ROWS / 2);
   localparam logic signed [12:0] ROW_MIN    = 13'(BALL_HEIGHT / 2);
   localparam logic signed [12:0] ROW_MAX    = 13'(DISP_ROWS - 1 - BALL_HEIGHT / 2);
   localparam logic signed [12:0] L_CONTACT  = 13'(L_PADDLE_CENTER_COL + PADDLE_WIDTH / 2 + BALL_WIDTH / 2);
   localparam logic signed [12:0] R_CONTACT  = 13'(R_PADDLE_CENTER_COL - PADDLE_WIDTH / 2 - BALL_WIDTH / 2);
   localparam logic signed [12:0] MISS_LO    = 13'(BALL_WIDTH / 2);
   localparam logic signed [12:0] MISS_HI    = 13'(DISP_COLS - 1 - BALL_WIDTH / 2);
   localparam logic signed [12:0] OVERLAP    = 13'((PADDLE_HEIGHT + BALL_HEIGHT) / 2);
   localparam logic signed [12:0] STEP_Y     = 13'(BALL_SPEED_Y);
   localparam logic [3:0]         SCORE_TOP  = 4'(SCORE_MAX);
   localparam int                 HOLD_W     = $clog2(SCORE_HOLD_FRAMES + 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SCORE_HOLD_FRAMES - 1);

   state_t            state;
   logic [11:0]       col, row;
   logic              dx_right, dy_down;
   logic [3:0]        score_p0, score_p1;
   logic              point_scored, game_over;
   logic [HOLD_W-1:0] hold_cnt;
   logic              serve_prev, serve_pend, last_scorer;

   logic signed [12:0] col_s, row_s, next_col, next_row, step_x;
   logic signed [12:0] l_diff, r_diff, l_abs, r_abs;
   logic               hit_l, hit_r, hit, miss, miss_hi, dy_upd;
   logic               serve_edge, hold_done, scorer_won, recentre;
   logic [11:0]        row_upd;

`ifdef BALL_SPEEDUP_EN
   localparam logic [12:0] SPEED_BASE = 13'(BALL_SPEED_X);
   localparam logic [12:0] SPEED_TOP  = 13'(2 * BALL_SPEED_X);
   logic [12:0] speed_x;
   logic [1:0]  hit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_x <= SPEED_BASE;
         hit_cnt <= '0;
      end else if (recentre) begin
         speed_x <= SPEED_BASE;
         hit_cnt <= '0;
      end else if (bus.frame_tick && state == PLAY && hit) begin
         hit_cnt <= hit_cnt + 2'd1;
         if (hit_cnt == 2'd3 && speed_x < SPEED_TOP) speed_x <= speed_x + 13'd1;
      end
   end

   assign step_x = $signed(speed_x);
`else
   assign step_x = 13'(BALL_SPEED_X);
`endif

   // Candidate move in signed arithmetic so overshoot past either edge stays comparable.
   always_comb begin
      col_s    = $signed({1'b0, col});
      row_s    = $signed({1'b0, row});
      next_col = dx_right ? col_s + step_x : col_s - step_x;
      next_row = dy_down ? row_s + STEP_Y : row_s - STEP_Y;
      l_diff   = row_s - $signed({1'b0, bus.l_paddle_center_row});
      r_diff   = row_s - $signed({1'b0, bus.r_paddle_center_row});
      l_abs    = l_diff[12] ? -l_diff : l_diff;
      r_abs    = r_diff[12] ? -r_diff : r_diff;
      hit_l    = !dx_right && (col_s >= L_CONTACT) && (next_col <= L_CONTACT) && (l_abs <= OVERLAP);
      hit_r    = dx_right && (col_s <= R_CONTACT) && (next_col >= R_CONTACT) && (r_abs <= OVERLAP);
      hit      = hit_l || hit_r;
      miss_hi  = next_col >= MISS_HI;
      miss     = !hit && ((next_col <= MISS_LO) || miss_hi);
      row_upd  = next_row[11:0];
      dy_upd   = dy_down;
      if (next_row < ROW_MIN) begin
         row_upd = ROW_MIN[11:0];
         dy_upd  = 1'b1;
      end else if (next_row > ROW_MAX) begin
         row_upd = ROW_MAX[11:0];
         dy_upd  = 1'b0;
      end
      serve_edge = bus.serve && !serve_prev;
      hold_done  = hold_cnt == HOLD_LAST;
      scorer_won = last_scorer ? (score_p1 == SCORE_TOP) : (score_p0 == SCORE_TOP);
      recentre   = bus.frame_tick &&
                   ((state == SCORED && hold_done && !scorer_won) || (state == GAME_OVER && serve_pend));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= SERVE_WAIT;
         col          <= CENTER_COL;
         row          <= CENTER_ROW;
         dx_right     <= 1'b1;
         dy_down      <= 1'b1;
         score_p0     <= '0;
         score_p1     <= '0;
         point_scored <= 1'b0;
         game_over    <= 1'b0;
         hold_cnt     <= '0;
         serve_prev   <= 1'b0;
         serve_pend   <= 1'b0;
         last_scorer  <= 1'b0;
      end else begin
         serve_prev   <= bus.serve;
         point_scored <= 1'b0;
         if (serve_edge) serve_pend <= 1'b1;
         case (state)
            SERVE_WAIT: begin
               if (bus.frame_tick && serve_pend) begin
                  if (!serve_edge) serve_pend <= 1'b0;
                  state <= PLAY;
               end
            end
            PLAY: begin
               if (bus.frame_tick) begin
                  // A miss freezes the ball at its last in-bounds position.
                  if (miss) begin
                     point_scored <= 1'b1;
                     last_scorer  <= !miss_hi;
                     if (miss_hi && score_p0 != SCORE_TOP) score_p0 <= score_p0 + 4'd1;
                     if (!miss_hi && score_p1 != SCORE_TOP) score_p1 <= score_p1 + 4'd1;
                     hold_cnt <= '0;
                     state    <= SCORED;
                  end else begin
                     col     <= hit_l ? L_CONTACT[11:0] : (hit_r ? R_CONTACT[11:0] : next_col[11:0]);
                     row     <= row_upd;
                     dy_down <= dy_upd;
                     if (hit_l) dx_right <= 1'b1;
                     if (hit_r) dx_right <= 1'b0;
                  end
               end
            end
            SCORED: begin
               serve_pend <= 1'b0;
               if (bus.frame_tick) begin
                  if (!hold_done) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end else if (scorer_won) begin
                     game_over <= 1'b1;
                     state     <= GAME_OVER;
                  end else begin
                     col      <= CENTER_COL;
                     row      <= CENTER_ROW;
                     dx_right <= !last_scorer;
                     dy_down  <= !dy_down;
                     state    <= SERVE_WAIT;
                  end
               end
            end
            GAME_OVER: begin
               if (bus.frame_tick && serve_pend) begin
                  if (!serve_edge) serve_pend <= 1'b0;
                  score_p0  <= '0;
                  score_p1  <= '0;
                  col       <= CENTER_COL;
                  row       <= CENTER_ROW;
                  dx_right  <= 1'b1;
                  dy_down   <= 1'b1;
                  game_over <= 1'b0;
                  state     <= SERVE_WAIT;
               end
            end
            default: state <= SERVE_WAIT;
         endcase
      end
   end

   assign bus.ball_center_col = col;
   assign bus.ball_center_row = row;
   assign bus.score_p0        = score_p0;
   assign bus.score_p1        = score_p1;
   assign bus.point_scored    = point_scored;
   assign bus.game_over       = game_over;
endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: bounce trajectory table plus serve, miss, game-over and reset sequences.
module tb_ball_motion;
   logic clk = 1'b0;
   logic rst_n;

   ball_motion_if bus ();

   ball_motion dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tick_no;
      int l_row;
      int r_row;
      int exp_col;
      int exp_row;
   } vec_t;

   vec_t vecs[9];
   int   checks   = 0;
   int   failures = 0;
   int   ticks_done;

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input int col, input int row,
                              input int s0, input int s1, input int go);
      check_val({name, ".col"}, int'(bus.ball_center_col), col);
      check_val({name, ".row"}, int'(bus.ball_center_row), row);
      check_val({name, ".score_p0"}, int'(bus.score_p0), s0);
      check_val({name, ".score_p1"}, int'(bus.score_p1), s1);
      check_val({name, ".game_over"}, int'(bus.game_over), go);
   endtask

   task automatic frameTicks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) bus.frame_tick = 1'b1;
         @(negedge clk) bus.frame_tick = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input int l_row, input int r_row, input int n);
      @(negedge clk);
      bus.l_paddle_center_row = 12'(l_row);
      bus.r_paddle_center_row = 12'(r_row);
      frameTicks(n);
   endtask

   task automatic pressServe();
      @(negedge clk) bus.serve = 1'b1;
      @(negedge clk) bus.serve = 1'b0;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One full right-side miss from SERVE_WAIT; odd/even points alternate vertical direction.
   task automatic playPoint(input int k);
      pressServe();
      frameTicks(1);
      frameTicks(99);
      check_val($sformatf("point%0d.score_p0", k), int'(bus.score_p0), k);
      check_val($sformatf("point%0d.col", k), int'(bus.ball_center_col), 792);
      frameTicks(60);
   endtask

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1,   329, 488, 404, 302};
      vecs[1] = '{93,  329, 488, 772, 486};
      vecs[2] = '{94,  329, 488, 776, 488};
      vecs[3] = '{95,  329, 488, 772, 490};
      vecs[4] = '{148, 329, 488, 560, 595};
      vecs[5] = '{149, 329, 488, 556, 593};
      vecs[6] = '{281, 329, 488, 28,  329};
      vecs[7] = '{282, 329, 488, 24,  327};
      vecs[8] = '{283, 329, 488, 28,  325};

      bus.frame_tick          = 1'b0;
      bus.serve               = 1'b0;
      bus.l_paddle_center_row = 12'd0;
      bus.r_paddle_center_row = 12'd0;
      rst_n                   = 1'b0;

      resetDut();
      checkOutput("reset", 400, 300, 0, 0, 0);
      check_val("reset.point_scored", int'(bus.point_scored), 0);
      frameTicks(10);
      checkOutput("idle", 400, 300, 0, 0, 0);

      // Right paddle bounce, bottom wall clamp, then left paddle bounce.
      resetDut();
      applyStimulus(329, 488, 0);
      pressServe();
      frameTicks(1);
      checkOutput("serve_tick", 400, 300, 0, 0, 0);
      ticks_done = 0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].l_row, vecs[i].r_row, vecs[i].tick_no - ticks_done);
         ticks_done = vecs[i].tick_no;
         checkOutput($sformatf("bounce_t%0d", vecs[i].tick_no), vecs[i].exp_col, vecs[i].exp_row, 0, 0, 0);
      end

      // Right-side miss with the paddle far away.
      resetDut();
      applyStimulus(300, 100, 0);
      pressServe();
      frameTicks(1);
      frameTicks(98);
      checkOutput("pre_miss", 792, 496, 0, 0, 0);
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      check_val("miss.point_scored_hi", int'(bus.point_scored), 1);
      @(negedge clk);
      check_val("miss.point_scored_lo", int'(bus.point_scored), 0);
      checkOutput("miss", 792, 496, 1, 0, 0);
      bus.r_paddle_center_row = 12'd2000;
      frameTicks(30);
      pressServe();
      frameTicks(29);
      checkOutput("hold59", 792, 496, 1, 0, 0);
      frameTicks(1);
      checkOutput("hold60", 400, 300, 1, 0, 0);
      frameTicks(2);
      checkOutput("serve_discarded", 400, 300, 1, 0, 0);
      pressServe();
      frameTicks(2);
      checkOutput("after_point_dir", 404, 298, 1, 0, 0);

      // Play on to seven left-player points.
      frameTicks(98);
      check_val("point2.score_p0", int'(bus.score_p0), 2);
      frameTicks(60);
      for (int k = 3; k <= 6; k++) playPoint(k);
      pressServe();
      frameTicks(100);
      checkOutput("point7", 792, 496, 7, 0, 0);
      frameTicks(60);
      checkOutput("game_over", 792, 496, 7, 0, 1);
      frameTicks(3);
      checkOutput("game_over_hold", 792, 496, 7, 0, 1);
      pressServe();
      frameTicks(1);
      checkOutput("new_game", 400, 300, 0, 0, 0);
      frameTicks(2);
      checkOutput("new_game_wait", 400, 300, 0, 0, 0);
      pressServe();
      frameTicks(2);
      checkOutput("new_game_move", 404, 302, 0, 0, 0);
      frameTicks(5);
      checkOutput("mid_play", 424, 312, 0, 0, 0);

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 400, 300, 0, 0, 0);
      check_val("async_reset.point_scored", int'(bus.point_scored), 0);
      @(negedge clk) rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
